// File: rtl/ff_bank_pkg.sv
// Shared types, SR 1/1 policy encodings and helpers for the ff_bank flip-flop bank.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_SR = 2'b10,
    MODE_JK = 2'b11
  } mode_e;

  localparam int unsigned SR11_HOLD = 0;
  localparam int unsigned SR11_CLR  = 1;
  localparam int unsigned SR11_SET  = 2;
  localparam int unsigned SR11_TGL  = 3;

  // Widest channel vector popcount accepts; narrower vectors are zero-extended.
  localparam int unsigned POP_W = 64;

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// One bistable channel: mode-selected next-state logic, change pulse and sticky SR 1/1 flag.
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter logic        RstVal    = 1'b0,
  parameter int unsigned Sr11Policy = SR11_HOLD
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  mode_e mode_i,
  input  logic  en_i,
  input  logic  a_i,
  input  logic  b_i,
  input  logic  load_i,
  input  logic  load_val_i,
  input  logic  err_clr_i,
  output logic  q_o,
  output logic  chg_o,
  output logic  sticky_o,
  output logic  invalid_o
);

  logic q_d, q_q;
  logic chg_q;
  logic sticky_d, sticky_q;
  logic invalid;

  always_comb begin
    q_d     = q_q;
    invalid = 1'b0;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      unique case (mode_i)
        MODE_D: q_d = a_i;
        MODE_T: q_d = q_q ^ a_i;
        MODE_SR: begin
          unique case ({a_i, b_i})
            2'b00: q_d = q_q;
            2'b01: q_d = 1'b0;
            2'b10: q_d = 1'b1;
            2'b11: begin
              invalid = 1'b1;
              if (Sr11Policy == SR11_CLR) begin
                q_d = 1'b0;
              end else if (Sr11Policy == SR11_SET) begin
                q_d = 1'b1;
              end else if (Sr11Policy == SR11_TGL) begin
                q_d = ~q_q;
              end else begin
                q_d = q_q;
              end
            end
            default: q_d = q_q;
          endcase
        end
        MODE_JK: begin
          unique case ({a_i, b_i})
            2'b00: q_d = q_q;
            2'b01: q_d = 1'b0;
            2'b10: q_d = 1'b1;
            2'b11: q_d = ~q_q;
            default: q_d = q_q;
          endcase
        end
        default: q_d = q_q;
      endcase
    end
  end

  // A new event wins over a simultaneous clear.
  assign sticky_d = invalid | (sticky_q & ~err_clr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q      <= RstVal;
      chg_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      chg_q    <= q_d ^ q_q;
      sticky_q <= sticky_d;
    end
  end

  assign q_o       = q_q;
  assign chg_o     = chg_q;
  assign sticky_o  = sticky_q;
  assign invalid_o = invalid;

endmodule

// File: rtl/ff_bank.sv
// Bank of WIDTH D/T/SR/JK cells with parallel load and a saturating invalid-event counter.
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      CNT_W       = 8,
  parameter logic [WIDTH-1:0] RST_VAL     = '0,
  parameter int unsigned      SR11_POLICY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_chg,
  output logic [WIDTH-1:0] err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned CntMax = (1 << CNT_W) - 1;

  mode_e            mode_sel;
  logic [WIDTH-1:0] invalid;
  int unsigned      pop;
  int unsigned      sum;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;

  assign mode_sel = mode_e'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RstVal    (RST_VAL[i]),
      .Sr11Policy(SR11_POLICY)
    ) u_cell (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .mode_i    (mode_sel),
      .en_i      (en[i]),
      .a_i       (a[i]),
      .b_i       (b[i]),
      .load_i    (load),
      .load_val_i(load_val[i]),
      .err_clr_i (err_clr),
      .q_o       (q[i]),
      .chg_o     (q_chg[i]),
      .sticky_o  (err_sticky[i]),
      .invalid_o (invalid[i])
    );
  end

  assign pop = popcount(POP_W'(invalid));

  always_comb begin
    sum       = 0;
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      sum = pop;
    end else begin
      sum = 32'(err_cnt_q) + pop;
    end
    if (sum > CntMax) begin
      err_cnt_d = CNT_W'(CntMax);
    end else begin
      err_cnt_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ff_bank.sv
// Directed bench for ff_bank: four instances share stimulus, one per SR 1/1 policy.
module tb_ff_bank;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic [7:0] en, a, b, load_val;
  logic       load, err_clr;

  logic [7:0] q0, q1, q2, q3;
  logic [7:0] c0, c1, c2, c3;
  logic [7:0] s0, s1, s2, s3;
  logic [7:0] n0, n1, n2;
  logic [3:0] n3;

  int checks   = 0;
  int failures = 0;

  ff_bank #(.SR11_POLICY(0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .a(a), .b(b), .load(load),
    .load_val(load_val), .err_clr(err_clr), .q(q0), .q_chg(c0), .err_sticky(s0), .err_cnt(n0)
  );
  ff_bank #(.SR11_POLICY(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .a(a), .b(b), .load(load),
    .load_val(load_val), .err_clr(err_clr), .q(q1), .q_chg(c1), .err_sticky(s1), .err_cnt(n1)
  );
  ff_bank #(.SR11_POLICY(2)) u_p2 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .a(a), .b(b), .load(load),
    .load_val(load_val), .err_clr(err_clr), .q(q2), .q_chg(c2), .err_sticky(s2), .err_cnt(n2)
  );
  ff_bank #(.SR11_POLICY(3), .CNT_W(4)) u_p3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .a(a), .b(b), .load(load),
    .load_val(load_val), .err_clr(err_clr), .q(q3), .q_chg(c3), .err_sticky(s3), .err_cnt(n3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [7:0] e, input logic [7:0] av,
                       input logic [7:0] bv, input logic ld, input logic [7:0] lv,
                       input logic clr);
    mode = m; en = e; a = av; b = bv; load = ld; load_val = lv; err_clr = clr;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    #12;
    rst_n = 1'b1;
    check("reset_q", 32'(q0), 32'h00);
    check("reset_cnt", 32'(n0), 32'h0);

    // Async reset mid-cycle from q=A5, err_cnt=3.
    drive(2'b00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hA5, 1'b0);
    step();
    drive(2'b10, 8'hFF, 8'h07, 8'h07, 1'b0, 8'h00, 1'b0);
    step();
    check("pre_rst_q", 32'(q0), 32'hA5);
    check("pre_rst_cnt", 32'(n0), 32'h3);
    check("pre_rst_sticky", 32'(s0), 32'h07);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_q", 32'(q0), 32'h00);
    check("async_cnt", 32'(n0), 32'h0);
    check("async_chg", 32'(c0), 32'h00);
    check("async_sticky", 32'(s0), 32'h00);
    drive(2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    #1;
    rst_n = 1'b1;

    // D then T then hold.
    drive(2'b00, 8'hFF, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    check("d_q", 32'(q0), 32'h3C);
    check("d_chg", 32'(c0), 32'h3C);
    drive(2'b01, 8'hFF, 8'h0F, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    check("t_q", 32'(q0), 32'h33);
    check("t_chg", 32'(c0), 32'h0F);
    drive(2'b01, 8'h00, 8'h0F, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    check("hold_q", 32'(q0), 32'h33);
    check("hold_chg", 32'(c0), 32'h00);

    // SR 1/1 policies from q=F0.
    drive(2'b00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hF0, 1'b0);
    step();
    drive(2'b10, 8'hFF, 8'h81, 8'h81, 1'b0, 8'h00, 1'b0);
    step();
    check("sr_hold_q", 32'(q0), 32'hF0);
    check("sr_clr_q", 32'(q1), 32'h70);
    check("sr_set_q", 32'(q2), 32'hF1);
    check("sr_tgl_q", 32'(q3), 32'h71);
    check("sr_sticky0", 32'(s0), 32'h81);
    check("sr_sticky3", 32'(s3), 32'h81);
    check("sr_cnt0", 32'(n0), 32'h2);
    check("sr_cnt3", 32'(n3), 32'h2);

    // JK toggle is never invalid.
    drive(2'b00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h0F, 1'b0);
    step();
    drive(2'b11, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    step();
    check("jk_q", 32'(q0), 32'hF0);
    check("jk_chg", 32'(c0), 32'hFF);
    check("jk_sticky", 32'(s0), 32'h81);
    check("jk_cnt", 32'(n0), 32'h2);

    // Clear, then saturate the 4-bit counter.
    drive(2'b10, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    step();
    check("clr_cnt", 32'(n3), 32'h0);
    check("clr_sticky", 32'(s0), 32'h00);
    drive(2'b10, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    step();
    check("sat_cnt_1", 32'(n3), 32'h8);
    step();
    check("sat_cnt_2", 32'(n3), 32'hF);
    step();
    check("sat_cnt_3", 32'(n3), 32'hF);
    check("wide_cnt_3", 32'(n0), 32'd24);
    drive(2'b10, 8'hFF, 8'h24, 8'h24, 1'b0, 8'h00, 1'b1);
    step();
    check("clr_set_cnt3", 32'(n3), 32'h2);
    check("clr_set_cnt0", 32'(n0), 32'h2);
    check("clr_set_sticky", 32'(s0), 32'h24);

    // Load overrides SR 1/1 and raises no errors.
    drive(2'b10, 8'hFF, 8'hFF, 8'hFF, 1'b1, 8'h5A, 1'b0);
    step();
    check("load_q0", 32'(q0), 32'h5A);
    check("load_q3", 32'(q3), 32'h5A);
    check("load_chg", 32'(c0), 32'hAA);
    check("load_sticky", 32'(s0), 32'h24);
    check("load_cnt", 32'(n0), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
